// File: rtl/shift_exec_unit.sv
// Execute-stage shift unit: two-stage valid/ready pipeline around logical barrel shifters.
// Define SHIFT_EXEC_ROTATE_EN to build the ROTR path; otherwise op 11 is flagged illegal.

module barrel_shifter32 (
    input  logic [31:0] data,
    input  logic [4:0]  amount,
    input  logic        direction,
    output logic [31:0] result
);
    logic [31:0] st [0:5];

    assign st[0] = data;

    for (genvar i = 0; i < 5; i++) begin : g_stage
        assign st[i+1] = !amount[i] ? st[i]
                       : direction  ? st[i] >> (2**i)
                       :              st[i] << (2**i);
    end

    assign result = st[5];
endmodule

module shift_exec_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [4:0]       in_amount,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] data;
        logic [4:0]       amount;
        logic [TAG_W-1:0] tag;
    } s1_t;

    localparam logic [31:0] ONES = '1;

    logic             s1_valid;
    s1_t              s1;
    logic             s2_valid;
    logic             s1_advance;
    logic             in_fire;

    logic [31:0]      shl;
    logic [31:0]      shr;
    logic [31:0]      fill_n;
    logic [WIDTH-1:0] res;
    logic             ill;

    assign s1_advance = s1_valid && (!s2_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = s2_valid;

    barrel_shifter32 u_left (
        .data      (s1.data),
        .amount    (s1.amount),
        .direction (1'b0),
        .result    (shl)
    );

    barrel_shifter32 u_right (
        .data      (s1.data),
        .amount    (s1.amount),
        .direction (1'b1),
        .result    (shr)
    );

    // Sign-fill mask is the complement of all-ones shifted right.
    barrel_shifter32 u_mask (
        .data      (ONES),
        .amount    (s1.amount),
        .direction (1'b1),
        .result    (fill_n)
    );

`ifdef SHIFT_EXEC_ROTATE_EN
    logic [4:0]  neg_amount;
    logic [31:0] wrap_raw;
    logic [31:0] wrap;

    assign neg_amount = 5'd0 - s1.amount;

    barrel_shifter32 u_wrap (
        .data      (s1.data),
        .amount    (neg_amount),
        .direction (1'b0),
        .result    (wrap_raw)
    );

    // A zero amount would wrap the whole word back in; suppress it.
    assign wrap = (s1.amount == 5'd0) ? '0 : wrap_raw;
`endif

    always_comb begin
        res = '0;
        ill = 1'b0;
        unique case (s1.op)
            OP_SLL:  res = shl;
            OP_SRL:  res = shr;
            OP_SRA:  res = shr | (s1.data[WIDTH-1] ? ~fill_n : '0);
            OP_ROTR: begin
`ifdef SHIFT_EXEC_ROTATE_EN
                res = shr | wrap;
`else
                ill = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1.op    <= op_e'(in_op);
            s1.data  <= in_data;
            s1.amount <= in_amount;
            s1.tag   <= in_tag;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_advance) begin
            s2_valid    <= 1'b1;
            out_result  <= res;
            out_tag     <= s1.tag;
            out_illegal <= ill;
        end else if (s2_valid && out_ready) begin
            s2_valid <= 1'b0;
        end
    end
endmodule
